// File: rtl/spike_event_fifo_writer.sv
// Producer side of the spike event FIFO.
// Accepts one spike row per handshake and writes one {row_idx, col_idx} word
// per set bit, lowest column first. After the last row of a timestep it writes
// an all-ones end-of-timestep marker.
//
// state  | meaning
// IDLE   | ready for a new row
// SCAN   | writing one event per set bit of the latched mask
// MARKER | writing the end-of-timestep marker word
module spike_event_fifo_writer #(
    parameter int ROW_WIDTH     = 32,
    parameter int COL_WIDTH     = $clog2(ROW_WIDTH),
    parameter int ROW_IDX_WIDTH = 8,
    parameter int DATA_WIDTH    = ROW_IDX_WIDTH + COL_WIDTH,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     row_valid,
    output logic                     row_ready,
    input  logic [ROW_WIDTH-1:0]     row_spikes,
    input  logic [ROW_IDX_WIDTH-1:0] row_idx,
    input  logic                     row_last,
    output logic [DATA_WIDTH-1:0]    fifo_write_data,
    output logic                     fifo_write_en,
    input  logic                     fifo_full,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     event_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        MARKER = 2'd2
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [ROW_WIDTH-1:0]      mask_q;
    logic [ROW_WIDTH-1:0]      mask_rest;
    logic [ROW_IDX_WIDTH-1:0]  row_idx_q;
    logic                      last_q;
    logic [COL_WIDTH-1:0]      col;

    // Index of the lowest set bit; descending loop lets the lowest hit win.
    always_comb begin
        col = '0;
        for (int i = ROW_WIDTH - 1; i >= 0; i--) begin
            if (mask_q[i]) begin
                col = COL_WIDTH'(i);
            end
        end
    end

    // x & (x-1) clears exactly the lowest set bit, i.e. bit col.
    assign mask_rest = mask_q & (mask_q - ROW_WIDTH'(1));

    // Next-state and write-side outputs; writes are suppressed while rst is high.
    always_comb begin
        state_next      = state;
        row_ready       = 1'b0;
        fifo_write_en   = 1'b0;
        fifo_write_data = '0;
        case (state)
            IDLE: begin
                row_ready = !rst;
                if (row_valid && !rst) begin
                    if (row_spikes != '0) begin
                        state_next = SCAN;
                    end else if (row_last) begin
                        state_next = MARKER;
                    end
                end
            end
            SCAN: begin
                fifo_write_en   = !fifo_full && !rst;
                fifo_write_data = {row_idx_q, col};
                if (fifo_write_en && (mask_rest == '0)) begin
                    state_next = last_q ? MARKER : IDLE;
                end
            end
            MARKER: begin
                fifo_write_en   = !fifo_full && !rst;
                fifo_write_data = '1;
                if (fifo_write_en) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Row latch, mask consumption and per-timestep event counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q      <= '0;
            row_idx_q   <= '0;
            last_q      <= 1'b0;
            event_count <= '0;
        end else begin
            if (row_ready && row_valid) begin
                mask_q    <= row_spikes;
                row_idx_q <= row_idx;
                last_q    <= row_last;
            end
            if (state == SCAN && fifo_write_en) begin
                mask_q <= mask_rest;
                if (event_count != '1) begin
                    event_count <= event_count + CNT_WIDTH'(1);
                end
            end
            if (state == MARKER && fifo_write_en) begin
                event_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spike_event_fifo_writer.sv
// Directed bench for spike_event_fifo_writer with hand-computed expectations.
module tb_spike_event_fifo_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        row_valid;
    logic        row_ready;
    logic [31:0] row_spikes;
    logic [7:0]  row_idx;
    logic        row_last;
    logic [12:0] fifo_write_data;
    logic        fifo_write_en;
    logic        fifo_full;
    logic        busy;
    logic [15:0] event_count;

    int n_checks = 0;
    int n_fail   = 0;

    spike_event_fifo_writer dut (
        .clk             (clk),
        .rst             (rst),
        .row_valid       (row_valid),
        .row_ready       (row_ready),
        .row_spikes      (row_spikes),
        .row_idx         (row_idx),
        .row_last        (row_last),
        .fifo_write_data (fifo_write_data),
        .fifo_write_en   (fifo_write_en),
        .fifo_full       (fifo_full),
        .busy            (busy),
        .event_count     (event_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Move 1 time unit past the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Apply all inputs for the current cycle and let combinational outputs settle.
    task automatic drive(input logic v, input logic [31:0] s, input logic [7:0] idx,
                         input logic l, input logic f, input logic r);
        row_valid  = v;
        row_spikes = s;
        row_idx    = idx;
        row_last   = l;
        fifo_full  = f;
        rst        = r;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with a row offered: nothing accepted, nothing written.
        drive(1'b1, 32'hF, 8'd1, 1'b0, 1'b0, 1'b1);
        check("rst_ready", 32'(row_ready), 32'd0);
        check("rst_wen", 32'(fifo_write_en), 32'd0);
        cyc();
        drive(1'b1, 32'hF, 8'd1, 1'b0, 1'b0, 1'b1);
        check("rst_ready2", 32'(row_ready), 32'd0);
        cyc();
        idle();
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_count", 32'(event_count), 32'd0);
        check("post_rst_ready", 32'(row_ready), 32'd1);
        check("post_rst_wen", 32'(fifo_write_en), 32'd0);

        // Row 0x15, idx 3: events 0x060, 0x062, 0x064.
        cyc();
        drive(1'b1, 32'h15, 8'd3, 1'b0, 1'b0, 1'b0);
        check("r15_ready", 32'(row_ready), 32'd1);
        cyc(); idle();
        check("r15_wen0", 32'(fifo_write_en), 32'd1);
        check("r15_data0", 32'(fifo_write_data), 32'h060);
        check("r15_ready_scan", 32'(row_ready), 32'd0);
        cyc(); idle();
        check("r15_wen1", 32'(fifo_write_en), 32'd1);
        check("r15_data1", 32'(fifo_write_data), 32'h062);
        cyc(); idle();
        check("r15_wen2", 32'(fifo_write_en), 32'd1);
        check("r15_data2", 32'(fifo_write_data), 32'h064);
        cyc(); idle();
        check("r15_ready_end", 32'(row_ready), 32'd1);
        check("r15_count", 32'(event_count), 32'd3);
        check("r15_wen_end", 32'(fifo_write_en), 32'd0);

        // Empty last row: only the marker.
        drive(1'b1, 32'h0, 8'd7, 1'b1, 1'b0, 1'b0);
        cyc(); idle();
        check("mk_wen", 32'(fifo_write_en), 32'd1);
        check("mk_data", 32'(fifo_write_data), 32'h1FFF);
        check("mk_count_before", 32'(event_count), 32'd3);
        cyc(); idle();
        check("mk_wen_after", 32'(fifo_write_en), 32'd0);
        check("mk_count_after", 32'(event_count), 32'd0);
        check("mk_ready_after", 32'(row_ready), 32'd1);

        // Full row, idx 2, last: 32 consecutive events then marker.
        drive(1'b1, 32'hFFFF_FFFF, 8'd2, 1'b1, 1'b0, 1'b0);
        cyc();
        for (int c = 0; c < 32; c++) begin
            idle();
            check("all_wen", 32'(fifo_write_en), 32'd1);
            check("all_data", 32'(fifo_write_data), 32'h40 + 32'(c));
            check("all_count", 32'(event_count), 32'(c));
            cyc();
        end
        idle();
        check("all_mk_wen", 32'(fifo_write_en), 32'd1);
        check("all_mk_data", 32'(fifo_write_data), 32'h1FFF);
        check("all_mk_count", 32'(event_count), 32'd32);
        cyc(); idle();
        check("all_count_after", 32'(event_count), 32'd0);
        check("all_wen_after", 32'(fifo_write_en), 32'd0);
        check("all_ready_after", 32'(row_ready), 32'd1);

        // Row 0x101, idx 1, with 4 cycles of backpressure.
        drive(1'b1, 32'h101, 8'd1, 1'b0, 1'b0, 1'b0);
        cyc();
        for (int k = 0; k < 4; k++) begin
            drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0);
            check("bp_wen_full", 32'(fifo_write_en), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            cyc();
        end
        idle();
        check("bp_wen0", 32'(fifo_write_en), 32'd1);
        check("bp_data0", 32'(fifo_write_data), 32'h020);
        cyc(); idle();
        check("bp_wen1", 32'(fifo_write_en), 32'd1);
        check("bp_data1", 32'(fifo_write_data), 32'h028);
        cyc(); idle();
        check("bp_ready_end", 32'(row_ready), 32'd1);
        check("bp_count", 32'(event_count), 32'd2);

        // Empty non-last row: no write, count kept.
        drive(1'b1, 32'h0, 8'd9, 1'b0, 1'b0, 1'b0);
        cyc(); idle();
        check("empty_busy", 32'(busy), 32'd0);
        check("empty_wen", 32'(fifo_write_en), 32'd0);
        check("empty_count", 32'(event_count), 32'd2);

        // Reset during the second event of a 4-spike row.
        drive(1'b1, 32'hF, 8'd4, 1'b0, 1'b0, 1'b0);
        cyc(); idle();
        check("mr_data0", 32'(fifo_write_data), 32'h080);
        check("mr_count0", 32'(event_count), 32'd2);
        cyc();
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b1);
        check("mr_wen_rst", 32'(fifo_write_en), 32'd0);
        check("mr_ready_rst", 32'(row_ready), 32'd0);
        cyc(); idle();
        check("mr_ready", 32'(row_ready), 32'd1);
        check("mr_count", 32'(event_count), 32'd0);
        check("mr_busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            check("mr_no_event", 32'(fifo_write_en), 32'd0);
            cyc(); idle();
        end

        // Row held valid during SCAN is accepted only after the prior row drains.
        drive(1'b1, 32'h6, 8'd5, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 32'h1, 8'd6, 1'b1, 1'b0, 1'b0);
        check("hold_ready0", 32'(row_ready), 32'd0);
        check("hold_data0", 32'(fifo_write_data), 32'h0A1);
        cyc();
        drive(1'b1, 32'h1, 8'd6, 1'b1, 1'b0, 1'b0);
        check("hold_ready1", 32'(row_ready), 32'd0);
        check("hold_data1", 32'(fifo_write_data), 32'h0A2);
        cyc();
        drive(1'b1, 32'h1, 8'd6, 1'b1, 1'b0, 1'b0);
        check("hold_ready_idle", 32'(row_ready), 32'd1);
        check("hold_wen_idle", 32'(fifo_write_en), 32'd0);
        cyc(); idle();
        check("hold_wen_b", 32'(fifo_write_en), 32'd1);
        check("hold_data_b", 32'(fifo_write_data), 32'h0C0);
        cyc(); idle();
        check("hold_mk_data", 32'(fifo_write_data), 32'h1FFF);
        check("hold_mk_count", 32'(event_count), 32'd3);
        cyc(); idle();
        check("hold_count_after", 32'(event_count), 32'd0);
        check("hold_busy_after", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
